// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS integer core. It takes one instruction at a time over a
//   valid/ready handshake. Each instruction then passes through FETCH, DECODE,
//   EXEC and WB. The core holds a 32-entry register file and the PC, and it
//   reports every register-writing result.
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-high
//   instr_valid   instr holds a valid instruction
//   instr         32-bit MIPS instruction word
//   instr_ready   high only in FETCH, core accepts instr
//   pc            address of the next instruction to accept
//   result        last written register value
//   result_valid  one-cycle pulse when result is updated
//   illegal       sticky flag, an unsupported instruction was seen
module mips_multicycle_core #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  state_t            state, next_state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, alu_res;
  logic              br_eq;
  logic [DATA_W-1:0] reg_file [32];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, dest;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val;
  logic              is_legal, writes_reg, use_imm, is_beq, is_bne, is_jr;
  logic [PC_W-1:0]   pc_plus4, br_target;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_ext  = DATA_W'($signed(ir[15:0]));
  assign rs_val   = (rs == 5'd0) ? '0 : reg_file[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : reg_file[rt];
  assign pc_plus4 = pc + PC_W'(4);
  assign br_target = pc_plus4 + (PC_W'($signed(ir[15:0])) << 2);

  assign instr_ready = (state == FETCH);

  // Classify the latched instruction. Unsupported encodings leave is_legal
  // low, and WB then treats them as a NOP that still advances the PC.
  always_comb begin
    is_legal   = 1'b0;
    writes_reg = 1'b0;
    use_imm    = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jr      = 1'b0;
    dest       = rd;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            is_legal   = 1'b1;
            writes_reg = 1'b1;
          end
          FN_JR: begin
            is_legal = 1'b1;
            is_jr    = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        is_legal   = 1'b1;
        writes_reg = 1'b1;
        use_imm    = 1'b1;
        dest       = rt;
      end
      OP_BEQ: begin
        is_legal = 1'b1;
        is_beq   = 1'b1;
      end
      OP_BNE: begin
        is_legal = 1'b1;
        is_bne   = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU. ADDI shares the add path because the immediate is already in B.
  always_comb begin
    alu_res = a + b;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = DATA_W'($signed(a) < $signed(b));
        default: alu_res = a + b;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // The FSM stays in FETCH until a handshake. After that it steps through
  // the other states unconditionally.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (instr_valid) next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Datapath. Writes to r0 are dropped, but result and result_valid still
  // report the computed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= PC_RESET;
      result       <= '0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      br_eq        <= 1'b0;
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        FETCH: if (instr_valid) ir <= instr;
        DECODE: begin
          a <= rs_val;
          b <= use_imm ? imm_ext : rt_val;
        end
        EXEC: begin
          alu_out <= alu_res;
          br_eq   <= (a == b);
        end
        WB: begin
          if (!is_legal) begin
            illegal <= 1'b1;
            pc      <= pc_plus4;
          end else begin
            if (writes_reg) begin
              result       <= alu_out;
              result_valid <= 1'b1;
              if (dest != 5'd0) reg_file[dest] <= alu_out;
            end
            if ((is_beq && br_eq) || (is_bne && !br_eq)) pc <= br_target;
            else if (is_jr)                              pc <= PC_W'(a);
            else                                         pc <= pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core
//   Testbench for mips_multicycle_core with the default parameters. It runs
//   directed instructions and then a random instruction stream. Every result
//   is compared with an instruction-level reference model of the architecture.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_result;
  logic        m_illegal;
  logic        m_valid;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .result       (result),
    .result_valid (result_valid),
    .illegal      (illegal)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc      = '0;
    m_result  = '0;
    m_illegal = 1'b0;
    m_valid   = 1'b0;
  endtask

  // Architectural behaviour of one instruction
  task automatic model_exec(input logic [31:0] w);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] x, y, simm, r, npc;
    logic [4:0]  dst;
    bit          wr, ok;
    op   = w[31:26];
    fn   = w[5:0];
    x    = m_regs[w[25:21]];
    y    = m_regs[w[20:16]];
    simm = {{16{w[15]}}, w[15:0]};
    npc  = m_pc + 4;
    wr   = 0;
    ok   = 1;
    r    = '0;
    dst  = w[15:11];
    if (op == 6'h00) begin
      wr = 1;
      case (fn)
        6'h20: r = x + y;
        6'h22: r = x - y;
        6'h24: r = x & y;
        6'h25: r = x | y;
        6'h2A: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        6'h08: begin wr = 0; npc = x; end
        default: begin wr = 0; ok = 0; end
      endcase
    end else if (op == 6'h08) begin
      wr  = 1;
      r   = x + simm;
      dst = w[20:16];
    end else if (op == 6'h04) begin
      if (x == y) npc = m_pc + 4 + simm * 4;
    end else if (op == 6'h05) begin
      if (x != y) npc = m_pc + 4 + simm * 4;
    end else begin
      ok = 0;
    end
    if (!ok) m_illegal = 1'b1;
    m_pc    = npc;
    m_valid = wr;
    if (wr) begin
      m_result = r;
      if (dst != 0) m_regs[dst] = r;
    end
  endtask

  // Performs one handshake and follows that instruction to completion
  task automatic apply_stimulus(input logic [31:0] w, input string tag);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({tag, ".ready"}, 32'(instr_ready), 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    model_exec(w);
    @(posedge clk); #1;
    check_output({tag, ".busy"}, 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output({tag, ".result_valid"}, 32'(result_valid), 32'(m_valid));
    check_output({tag, ".result"}, result, m_result);
    check_output({tag, ".pc"}, pc, m_pc);
    check_output({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
    check_output({tag, ".ready_again"}, 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check_output({tag, ".pulse_end"}, 32'(result_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, ".pc"}, pc, 32'd0);
    check_output({tag, ".result"}, result, 32'd0);
    check_output({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    check_output({tag, ".illegal"}, 32'(illegal), 32'd0);
    check_output({tag, ".ready"}, 32'(instr_ready), 32'd1);
  endtask

  function automatic logic [31:0] random_instr();
    int          kind;
    logic [4:0]  s, t, d;
    logic [5:0]  bad;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    kind = $urandom_range(0, 20);
    s    = 5'($urandom_range(0, 7));
    t    = 5'($urandom_range(0, 7));
    d    = 5'($urandom_range(0, 7));
    if (kind < 10) return {6'h00, s, t, d, 5'h00, fns[kind % 5]};
    if (kind < 15) return {6'h08, s, t, 16'($urandom)};
    if (kind < 17) return {6'h04, s, t, 16'($urandom_range(0, 6) - 3)};
    if (kind < 19) return {6'h05, s, t, 16'($urandom_range(0, 6) - 3)};
    if (kind == 19) begin
      do bad = 6'($urandom_range(1, 63));
      while (bad == 6'h04 || bad == 6'h05 || bad == 6'h08);
      return {bad, 26'($urandom)};
    end
    return {6'h00, s, 5'h00, 5'h00, 5'h00, 6'h08};
  endfunction

  initial begin
    logic [31:0] hold_pc, hold_result;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    model_reset();
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed sequence");
    apply_stimulus(32'h20010005, "addi_r1");
    apply_stimulus(32'h2002FFFD, "addi_r2");
    apply_stimulus(32'h0041182A, "slt_r3");
    apply_stimulus(32'h00222022, "sub_r4");
    apply_stimulus(32'h10210002, "beq_taken");
    apply_stimulus(32'h14210002, "bne_not_taken");
    apply_stimulus(32'h20000007, "addi_r0");
    apply_stimulus(32'h00002820, "add_r5_r0");
    apply_stimulus(32'h20060040, "addi_r6");
    apply_stimulus(32'h00C00008, "jr_r6");
    apply_stimulus(32'hFC000000, "illegal_op");
    apply_stimulus(32'h20080001, "illegal_sticky");

    // Reset while the FSM is in EXEC
    instr       = 32'h00213820;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("reset_mid_exec");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("after_reset.ready", 32'(instr_ready), 32'd1);
    apply_stimulus(32'h00213820, "add_r7_after_reset");

    hold_pc     = pc;
    hold_result = result;
    repeat (10) @(posedge clk);
    #1;
    check_output("idle.pc", pc, hold_pc);
    check_output("idle.result", result, hold_result);
    check_output("idle.result_valid", 32'(result_valid), 32'd0);

    $display("[TB] random sequence");
    for (int i = 0; i < 60; i++) apply_stimulus(random_instr(), $sformatf("rand%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle MIPS integer core: accepts one 32-bit instruction at a time over a valid/ready handshake, executes it through a four-state FSM (FETCH, DECODE, EXEC, WB), maintains a register file and PC, and reports register-writing results. Adds configurable datapath/PC width, signed SLT, OR, taken-branch/JR PC update, r0 hardwiring and illegal-instruction detection. Sits between the instruction source and downstream result consumers.

## Interface
- DATA_W, 32, datapath and register width (≥16)
- PC_W, 32, program counter width
- PC_RESET, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- instr_valid  in  1  instr holds a valid instruction
- instr  in  32  MIPS instruction word
- instr_ready  out  1  core in FETCH, will accept instr
- pc  out  PC_W  address of the next instruction to accept
- result  out  DATA_W  last written register value
- result_valid  out  1  one-cycle pulse, result updated
- illegal  out  1  sticky: unsupported instruction seen

## Operation
- Registers: 32 × DATA_W; r0 reads 0, writes to r0 discarded (result_valid still pulses, result = computed value).
- Decode: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0] sign-extended to DATA_W.
- Supported: R-type (op 0) ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A write rd; JR 0x08 no write. ADDI 0x08 writes rt. BEQ 0x04, BNE 0x05 no write.
- ADD/SUB/ADDI wrap modulo 2^DATA_W, no overflow trap. SLT signed compare, result 1 or 0.
- PC update at WB: BEQ/BNE taken → pc+4+(sext(imm)<<2); JR → reg[rs][PC_W-1:0]; otherwise pc+4. All modulo 2^PC_W.
- Unsupported op/funct: executes as NOP (pc+4, no write, no result_valid), sets illegal until reset.
- FSM: FETCH —(instr_valid && instr_ready)→ DECODE (latch IR) → EXEC (latch A=reg[rs], B=reg[rt] or imm) → WB (latch ALU out, branch compare) → FETCH (reg write, PC update, result/result_valid update).
- instr_ready = 1 only in FETCH; instr ignored in all other states.

## Timing
- Reset (async, any state): FSM=FETCH, pc=PC_RESET, result=0, result_valid=0, illegal=0, all registers 0, IR cleared. In-flight instruction discarded, no write.
- Handshake at edge N → register write, pc update and result_valid visible after edge N+3; instr_ready high again after edge N+3. Throughput 1 instruction / 4 cycles with instr_valid held high.
- result_valid high exactly one cycle; result holds value until next write.
- Operands read in DECODE→EXEC, so back-to-back dependent instructions see prior WB value (no hazards).
- instr_valid low in FETCH: core idles, all outputs stable.

## Test plan
- Reset, ADDI r1,r0,5 (0x20010005) → 4 cycles after handshake result=5, result_valid one cycle, pc=4.
- ADDI r2,r0,-3 (0x2002FFFD); SLT r3,r2,r1 (0x0041182A) → result=1; SUB r4,r1,r2 (0x00222022) → result=8 (DATA_W=32); pc=16.
- BEQ r1,r1,+2 (0x10210002) at pc=16 → pc=28, no result_valid; BNE r1,r1,+2 (0x14210002) → pc+4.
- ADDI r0,r0,7 (0x20000007) then ADD r5,r0,r0 (0x00002820) → second result=0; ADDI r6,r0,0x40, JR r6 (0x00C00008) → pc=0x40.
- Opcode 0x3F instruction → illegal=1, pc+4, no result_valid; illegal stays 1 until reset.
- Reset asserted mid-EXEC → outputs reset values immediately, instr_ready=1 next cycle; then ADD r7,r1,r1 → result=0. With instr_valid low 10 cycles in FETCH, pc/result unchanged.
